// File: rtl/elevator_pkg.sv
// Shared codes, state/direction types and position helpers for the elevator
// controller and its call scheduler. Floor index 0..2 means floor1..floor3.
package elevator_pkg;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_F1   = 2'b01;
    localparam logic [1:0] REQ_F2   = 2'b10;
    localparam logic [1:0] REQ_F3   = 2'b11;

    localparam logic [1:0] POS_F1   = 2'b00;
    localparam logic [1:0] POS_F2   = 2'b01;
    localparam logic [1:0] POS_MOV2 = 2'b10;
    localparam logic [1:0] POS_F3   = 2'b11;

    typedef enum logic [1:0] {IDLE, TRAVEL, DOOR} state_t;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    function automatic logic [1:0] expected_pos(input logic [1:0] idx);
        case (idx)
            2'd0:    return POS_F1;
            2'd1:    return POS_F2;
            default: return POS_F3;
        endcase
    endfunction

    function automatic logic [1:0] req_code(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

    function automatic logic [1:0] pos_to_idx(input logic [1:0] p);
        case (p)
            POS_F2:  return 2'd1;
            POS_F3:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_select.sv
// Collective target choice: keep going the current way while calls remain
// ahead (or at the current floor), otherwise reverse.
module call_target_select
    import elevator_pkg::*;
(
    input  logic [2:0] pending,
    input  logic [1:0] cur_floor,
    input  dir_t       dir,
    output logic [1:0] target,
    output dir_t       new_dir,
    output logic       valid
);

    logic found;

    always_comb begin
        target  = 2'd0;
        new_dir = dir;
        valid   = |pending;
        found   = 1'b0;
        if (dir == DIR_UP) begin
            // descending scan so the lowest qualifying floor is the last written
            for (int i = 2; i >= 0; i--) begin
                if (pending[i] && (2'(i) >= cur_floor)) begin
                    target = 2'(i);
                    found  = 1'b1;
                end
            end
            if (!found && valid) begin
                new_dir = DIR_DOWN;
                for (int i = 0; i < 3; i++) begin
                    if (pending[i] && (2'(i) < cur_floor)) target = 2'(i);
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pending[i] && (2'(i) <= cur_floor)) begin
                    target = 2'(i);
                    found  = 1'b1;
                end
            end
            if (!found && valid) begin
                new_dir = DIR_UP;
                for (int i = 2; i >= 0; i--) begin
                    if (pending[i] && (2'(i) > cur_floor)) target = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches hall calls, dispatches one target at a time to the controller,
// detects arrival from its position code, then runs the door dwell.
//   state  | meaning
//   IDLE   | no target; dispatch when any call is pending
//   TRAVEL | floor request driven, waiting for arrival or timeout
//   DOOR   | door dwell after arrival
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    input  logic [1:0] pos,
    output logic [1:0] floor,
    output logic [2:0] pending,
    output logic       busy,
    output logic       door_open,
    output logic       served,
    output logic       err
);

    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nx;
    dir_t             dir, dir_nx, sel_dir;
    logic [1:0]       cur_floor, target, target_nx, sel_target, floor_nx;
    logic [CNT_W-1:0] counter, counter_nx;
    logic [2:0]       pending_nx, absorb, clear, target_bit;
    logic             sel_valid, arrive, busy_nx, door_nx, served_nx, err_nx;

    call_target_select u_select (
        .pending   (pending),
        .cur_floor (cur_floor),
        .dir       (dir),
        .target    (sel_target),
        .new_dir   (sel_dir),
        .valid     (sel_valid)
    );

    assign target_bit = 3'b001 << target;
    assign arrive     = (pos == expected_pos(target));

    always_comb begin
        state_nx   = state;
        dir_nx     = dir;
        target_nx  = target;
        counter_nx = counter;
        floor_nx   = floor;
        busy_nx    = busy;
        door_nx    = door_open;
        served_nx  = 1'b0;
        err_nx     = 1'b0;
        absorb     = 3'b000;
        clear      = 3'b000;
        case (state)
            IDLE: begin
                floor_nx = REQ_NONE;
                if (sel_valid) begin
                    target_nx  = sel_target;
                    dir_nx     = sel_dir;
                    floor_nx   = req_code(sel_target);
                    counter_nx = '0;
                    busy_nx    = 1'b1;
                    state_nx   = TRAVEL;
                end
            end
            TRAVEL: begin
                absorb     = target_bit;
                counter_nx = counter + CNT_W'(1);
                if (arrive) begin
                    served_nx  = 1'b1;
                    clear      = target_bit;
                    floor_nx   = REQ_NONE;
                    door_nx    = 1'b1;
                    counter_nx = '0;
                    state_nx   = DOOR;
                end else if (counter == TIMEOUT_LAST) begin
                    err_nx     = 1'b1;
                    clear      = target_bit;
                    floor_nx   = REQ_NONE;
                    busy_nx    = 1'b0;
                    counter_nx = '0;
                    state_nx   = IDLE;
                end
            end
            DOOR: begin
                absorb     = target_bit;
                counter_nx = counter + CNT_W'(1);
                if (counter == DWELL_LAST) begin
                    door_nx    = 1'b0;
                    busy_nx    = 1'b0;
                    counter_nx = '0;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        pending_nx = (pending | (btn & ~absorb)) & ~clear;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            dir       <= DIR_UP;
            cur_floor <= 2'd0;
            target    <= 2'd0;
            counter   <= '0;
            floor     <= REQ_NONE;
            pending   <= 3'b000;
            busy      <= 1'b0;
            door_open <= 1'b0;
            served    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            dir       <= dir_nx;
            target    <= target_nx;
            counter   <= counter_nx;
            floor     <= floor_nx;
            pending   <= pending_nx;
            busy      <= busy_nx;
            door_open <= door_nx;
            served    <= served_nx;
            err       <= err_nx;
            // position code 10 is between floors, so the last floor is kept
            if (pos != POS_MOV2) cur_floor <= pos_to_idx(pos);
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: dispatch table plus
// hand-written arrival, dwell, timeout, absorb and reset sequences.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] btn = 3'b000;
    logic [1:0] pos = 2'b00;
    logic [1:0] floor;
    logic [2:0] pending;
    logic       busy, door_open, served, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    elevator_call_scheduler #(
        .DWELL_CYCLES   (4),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .pos       (pos),
        .floor     (floor),
        .pending   (pending),
        .busy      (busy),
        .door_open (door_open),
        .served    (served),
        .err       (err)
    );

    typedef struct {
        logic [1:0] pos;
        logic [2:0] btn;
        logic [1:0] exp_floor;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn = 3'b000;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic set_pos(input logic [1:0] p);
        pos = p;
        step();
    endtask

    task automatic press(input logic [2:0] b);
        btn = b;
        step();
        btn = 3'b000;
    endtask

    task automatic count_door(input string name, input int exp);
        int n = 0;
        for (int k = 0; k < 20 && door_open; k++) begin
            n++;
            step();
        end
        check(name, 8'(n), 8'(exp));
    endtask

    task automatic wait_floor(input string name, input logic [1:0] exp);
        int k = 0;
        while (floor == 2'b00 && k < 20) begin
            step();
            k++;
        end
        check(name, 8'(floor), 8'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, issued1, issued3;
        logic [1:0] prev;

        vecs[0] = '{2'b00, 3'b001, 2'b01};
        vecs[1] = '{2'b00, 3'b110, 2'b10};
        vecs[2] = '{2'b01, 3'b101, 2'b11};
        vecs[3] = '{2'b11, 3'b011, 2'b10};
        vecs[4] = '{2'b11, 3'b001, 2'b01};
        vecs[5] = '{2'b01, 3'b001, 2'b01};
        vecs[6] = '{2'b01, 3'b010, 2'b10};
        vecs[7] = '{2'b10, 3'b011, 2'b01};

        // reset with all buttons held
        rst = 1'b0;
        btn = 3'b111;
        step();
        step();
        check("rst_floor", 8'(floor), 8'h0);
        check("rst_pending", 8'(pending), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_door", 8'(door_open), 8'h0);
        rst = 1'b1;
        btn = 3'b000;

        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_pos(vecs[i].pos);
            press(vecs[i].btn);
            check("vec_latch", 8'(pending), 8'(vecs[i].btn));
            check("vec_no_early_floor", 8'(floor), 8'h0);
            step();
            check("vec_dispatch", 8'(floor), 8'(vecs[i].exp_floor));
            check("vec_busy", 8'(busy), 8'h1);
        end

        // single call floor1 -> floor3
        do_reset();
        set_pos(2'b00);
        press(3'b100);
        check("sc_pending", 8'(pending), 8'h4);
        check("sc_floor_n", 8'(floor), 8'h0);
        step();
        check("sc_floor_n1", 8'(floor), 8'h3);
        pos = 2'b10;
        step();
        check("sc_mov_no_serve", 8'(served), 8'h0);
        check("sc_mov_floor", 8'(floor), 8'h3);
        pos = 2'b11;
        step();
        check("sc_served", 8'(served), 8'h1);
        check("sc_door", 8'(door_open), 8'h1);
        check("sc_floor_off", 8'(floor), 8'h0);
        check("sc_pending_clr", 8'(pending), 8'h0);
        step();
        check("sc_served_pulse", 8'(served), 8'h0);
        count_door("sc_dwell", 3);
        check("sc_idle_busy", 8'(busy), 8'h0);
        check("sc_idle_floor", 8'(floor), 8'h0);

        // direction: from floor2 going up, floor3 before floor1
        do_reset();
        set_pos(2'b01);
        press(3'b101);
        check("dir_pending", 8'(pending), 8'h5);
        step();
        check("dir_first", 8'(floor), 8'h3);
        pos = 2'b10;
        step();
        pos = 2'b11;
        step();
        check("dir_served3", 8'(served), 8'h1);
        check("dir_pending1", 8'(pending), 8'h1);
        count_door("dir_dwell3", 4);
        wait_floor("dir_second", 2'b01);
        pos = 2'b10;
        step();
        pos = 2'b01;
        step();
        check("dir_pass_f2", 8'(served), 8'h0);
        pos = 2'b00;
        step();
        check("dir_served1", 8'(served), 8'h1);
        check("dir_pending0", 8'(pending), 8'h0);
        count_door("dir_dwell1", 4);

        // timeout
        do_reset();
        set_pos(2'b00);
        press(3'b010);
        step();
        check("to_dispatch", 8'(floor), 8'h2);
        n = 0;
        while (!err && n < 40) begin
            step();
            n++;
        end
        check("to_cycles", 8'(n), 8'd16);
        check("to_pending", 8'(pending), 8'h0);
        check("to_floor", 8'(floor), 8'h0);
        check("to_busy", 8'(busy), 8'h0);
        step();
        check("to_err_pulse", 8'(err), 8'h0);
        check("to_no_redispatch", 8'(floor), 8'h0);

        // arrival on the last timeout cycle wins
        do_reset();
        set_pos(2'b00);
        press(3'b010);
        step();
        repeat (15) step();
        check("edge_no_err", 8'(err), 8'h0);
        pos = 2'b01;
        step();
        check("edge_served", 8'(served), 8'h1);
        check("edge_err", 8'(err), 8'h0);
        check("edge_door", 8'(door_open), 8'h1);

        // absorb target press, queue floor1
        do_reset();
        set_pos(2'b00);
        press(3'b100);
        step();
        check("abs_dispatch", 8'(floor), 8'h3);
        pos = 2'b10;
        press(3'b101);
        check("abs_travel_pending", 8'(pending), 8'h5);
        pos = 2'b11;
        step();
        check("abs_arrive_pending", 8'(pending), 8'h1);
        step();
        press(3'b100);
        check("abs_door_pending", 8'(pending), 8'h1);
        issued1 = 0;
        issued3 = 0;
        prev = floor;
        for (int k = 0; k < 40; k++) begin
            step();
            if (floor == 2'b01 && prev != 2'b01) issued1++;
            if (floor == 2'b11 && prev != 2'b11) issued3++;
            if (floor == 2'b01) pos = 2'b00;
            prev = floor;
        end
        check("abs_issued_f1", 8'(issued1), 8'd1);
        check("abs_issued_f3", 8'(issued3), 8'd0);
        check("abs_final_pending", 8'(pending), 8'h0);
        check("abs_final_floor", 8'(floor), 8'h0);

        // reset in the middle of TRAVEL, direction DOWN beforehand
        do_reset();
        set_pos(2'b11);
        press(3'b001);
        step();
        check("mr_dispatch", 8'(floor), 8'h1);
        pos = 2'b10;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mr_floor", 8'(floor), 8'h0);
        check("mr_pending", 8'(pending), 8'h0);
        check("mr_busy", 8'(busy), 8'h0);
        check("mr_door", 8'(door_open), 8'h0);
        check("mr_served", 8'(served), 8'h0);
        check("mr_err", 8'(err), 8'h0);
        step();
        step();
        check("mr_discarded", 8'(floor), 8'h0);
        set_pos(2'b01);
        press(3'b101);
        step();
        check("mr_dir_up", 8'(floor), 8'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
